ifetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle RV32I core, directly upstream of the decoder/register-file stage. Holds the program counter, drives a synchronous instruction ROM with the *next* PC so that one instruction is presented per cycle without bubbles, and resolves branches and jumps from decoder/ALU feedback. It also counts retired instructions and halts in a trap state on a misaligned control-flow target.

---
 rtl/ifetch_unit.sv | 127 ++++++++++++
 tb/tb_ifetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC steering into a synchronous ROM,
// branch/jump redirect resolution, retired-instruction counter and misaligned-target trap.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch,
  input  logic                   jal,
  input  logic                   jalr,
  input  logic [31:0]            imm32,
  input  logic [31:0]            read_data1,
  input  logic                   alu_zero,
  input  logic                   alu_lt,
  input  logic                   alu_ltu,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            Instruction,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   trap,
  output logic [31:0]            instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        taken;
  logic [31:0] next_pc;
  logic        advance;
  logic        misaligned;

  // Branch condition decoded straight from ROM data (only consulted while in RUN)
  always_comb begin
    taken = 1'b0;
    case (imem_rdata[14:12])
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Redirect priority: JALR, then JAL, then taken branch, else sequential
  always_comb begin
    next_pc = pc + 32'd4;
    if (jalr) begin
      next_pc = (read_data1 + imm32) & ~32'h0000_0001;
    end else if (jal) begin
      next_pc = pc + imm32;
    end else if (branch && taken) begin
      next_pc = pc + imm32;
    end
  end

  assign advance    = (state == RUN) && !stall;
  assign misaligned = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    state_next = RUN;
      RUN:     if (advance && misaligned) state_next = TRAP;
      TRAP:    state_next = TRAP;
      default: state_next = FILL;
    endcase
  end

  // The ROM is addressed with the PC that will be current after the next edge
  always_comb begin
    instr_valid = 1'b0;
    Instruction = NOP;
    trap        = 1'b0;
    imem_addr   = pc[IMEM_ADDR_W+1:2];
    case (state)
      FILL: begin
        imem_addr = RESET_PC[IMEM_ADDR_W+1:2];
      end
      RUN: begin
        instr_valid = 1'b1;
        Instruction = imem_rdata;
        if (!stall) imem_addr = next_pc[IMEM_ADDR_W+1:2];
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        imem_addr = RESET_PC[IMEM_ADDR_W+1:2];
      end
    endcase
  end

  // A faulting target neither updates the PC nor retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instret <= 32'd0;
    end else if (advance && !misaligned) begin
      pc      <= next_pc;
      instret <= instret + 32'd1;
    end
  end

  assign pc_plus4 = pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vectors, corner-case sequences and
// randomized traffic compared against a cycle-level architectural model.
module tb_ifetch_unit;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          branch = 1'b0;
  logic          jal = 1'b0;
  logic          jalr = 1'b0;
  logic [31:0]   imm32 = 32'd0;
  logic [31:0]   read_data1 = 32'd0;
  logic          alu_zero = 1'b0;
  logic          alu_lt = 1'b0;
  logic          alu_ltu = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic [31:0]   Instruction;
  logic          instr_valid;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          trap;
  logic [31:0]   instret;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jal(jal), .jalr(jalr),
    .imm32(imm32), .read_data1(read_data1), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .alu_ltu(alu_ltu), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:(1<<AW)-1];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // Architectural model: 0 = filling, 1 = running, 2 = trapped
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        br, jl, jr, st, z, lt, ltu;
    logic [31:0] imm, rd1, exp_pc;
    logic        exp_trap;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next();
    logic [31:0] ins;
    logic        cond;
    ins = rom[m_pc[AW+1:2]];
    case (ins[14:12])
      3'b000:  cond = alu_zero;
      3'b001:  cond = !alu_zero;
      3'b100:  cond = alu_lt;
      3'b101:  cond = !alu_lt;
      3'b110:  cond = alu_ltu;
      3'b111:  cond = !alu_ltu;
      default: cond = 1'b0;
    endcase
    if (jalr) return (read_data1 + imm32) & 32'hFFFF_FFFE;
    if (jal) return m_pc + imm32;
    if (branch && cond) return m_pc + imm32;
    return m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] ref_addr();
    logic [31:0] np;
    if (m_mode == 0) return 32'd0;
    if (m_mode == 1 && !stall) begin
      np = ref_next();
      return 32'(np[AW+1:2]);
    end
    return 32'(m_pc[AW+1:2]);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc = 32'd0;
    m_instret = 32'd0;
  endtask

  task automatic model_edge();
    logic [31:0] np;
    if (reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      np = ref_next();
      if (np[1:0] != 2'b00) m_mode = 2;
      else begin
        m_pc = np;
        m_instret = m_instret + 32'd1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(m_mode == 1));
    chk({tag, ".instr"}, Instruction, (m_mode == 1) ? rom[m_pc[AW+1:2]] : 32'h13);
    chk({tag, ".trap"}, 32'(trap), 32'(m_mode == 2));
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".instret"}, instret, m_instret);
    chk({tag, ".addr"}, 32'(imem_addr), ref_addr());
  endtask

  // Entered at posedge+1; checks at posedge+4, returns at next posedge+1
  task automatic step(input string tag);
    #3;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_in();
    stall = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm32 = 32'd0; read_data1 = 32'd0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h13;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h0020_0193;
    rom[3] = 32'h0030_0213;

    //          f3      br    jl    jr    st    z     lt    ltu   imm            rd1            exp_pc         trap
    vt[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h18,        1'b0};
    vt[1]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h24,        1'b0};
    vt[2]  = '{3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h18,        1'b0};
    vt[3]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h24,        1'b0};
    vt[4]  = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h18,        1'b0};
    vt[5]  = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h24,        1'b0};
    vt[6]  = '{3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h18,        1'b0};
    vt[7]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h24,        1'b0};
    vt[8]  = '{3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h101,       32'h100,       1'b0};
    vt[9]  = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,        32'h0,         32'h60,        1'b0};
    vt[10] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,        32'h0,         32'h20,        1'b0};
    vt[11] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h102,       32'h20,        1'b1};
    vt[12] = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,         32'h0,         32'h20,        1'b1};
    vt[13] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h103,       32'h20,        1'b1};

    model_reset();
    clear_in();
    @(posedge clk);
    #1;

    // Reset held 3 cycles, then fill, then first instruction
    do_reset(3);
    chk("fill.addr", 32'(imem_addr), 32'h0);
    step("fill");
    chk("first.instr", Instruction, 32'h0050_0093);
    chk("first.pc", pc, 32'h0);
    chk("first.instret", instret, 32'h0);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq.pc", pc, 32'(i * 4));
      chk("seq.pc4", pc_plus4, 32'(i * 4 + 4));
      if (i == 3) chk("seq.instret", instret, 32'd3);
      if (i < 3) step("seq");
    end

    // Table of redirects issued from pc=0x20
    for (int v = 0; v < 14; v++) begin
      w = 32'h0000_0063;
      w[14:12] = vt[v].f3;
      rom[8] = w;
      clear_in();
      do_reset(1);
      step("vfill");
      jal = 1'b1; imm32 = 32'h20;
      step("vjmp");
      clear_in();
      chk("vec.start", pc, 32'h20);
      branch = vt[v].br; jal = vt[v].jl; jalr = vt[v].jr; stall = vt[v].st;
      alu_zero = vt[v].z; alu_lt = vt[v].lt; alu_ltu = vt[v].ltu;
      imm32 = vt[v].imm; read_data1 = vt[v].rd1;
      step("vec");
      chk($sformatf("vec%0d.pc", v), pc, vt[v].exp_pc);
      chk($sformatf("vec%0d.trap", v), 32'(trap), 32'(vt[v].exp_trap));
    end

    // Misaligned JALR traps and holds until reset
    clear_in();
    do_reset(1);
    step("tfill");
    jalr = 1'b1; read_data1 = 32'h102;
    step("tjalr");
    chk("trap.set", 32'(trap), 32'd1);
    chk("trap.pc", pc, 32'h0);
    chk("trap.valid", 32'(instr_valid), 32'd0);
    chk("trap.instret", instret, 32'd0);
    clear_in();
    for (int i = 0; i < 10; i++) begin
      step("thold");
      chk("trap.hold", 32'(trap), 32'd1);
    end
    do_reset(1);
    chk("trap.clear", 32'(trap), 32'd0);

    // Stall against a pending JAL, then release
    step("sfill");
    step("sseq");
    stall = 1'b1; jal = 1'b1; imm32 = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.pc", pc, 32'h4);
      chk("stall.instret", instret, 32'd1);
      chk("stall.addr", 32'(imem_addr), 32'h1);
    end
    stall = 1'b0;
    step("srel");
    chk("srel.pc", pc, 32'h44);

    // Wrap past the top of the address space
    imm32 = 32'hFFFF_FFB8;
    step("wjmp");
    chk("wrap.top", pc, 32'hFFFF_FFFC);
    clear_in();
    step("wseq");
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.instret", instret, 32'd4);

    // Reset pulse in the middle of a cycle
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("mid");
    chk("mid.pc", pc, 32'h0);
    chk("mid.valid", 32'(instr_valid), 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Randomized traffic over a random ROM
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    clear_in();
    do_reset(2);
    begin
      int trap_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
        if (m_mode == 2) trap_cycles++;
        if (trap_cycles > 4 || $urandom_range(0, 399) == 0) begin
          trap_cycles = 0;
          clear_in();
          do_reset($urandom_range(1, 3));
        end else begin
          stall      = ($urandom_range(0, 7) == 0);
          branch     = ($urandom_range(0, 3) == 0);
          jal        = ($urandom_range(0, 5) == 0);
          jalr       = ($urandom_range(0, 5) == 0);
          alu_zero   = 1'($urandom);
          alu_lt     = 1'($urandom);
          alu_ltu    = 1'($urandom);
          imm32      = $urandom;
          read_data1 = $urandom;
          if ($urandom_range(0, 31) != 0) imm32[1:0] = 2'b00;
          if ($urandom_range(0, 31) != 0) read_data1[1] = 1'b0;
          step("rnd");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
